serial_to_parallel_receiver: RTL and testbench

//  Downstream stage of the parallel interface.
//  - Consumes the LSB-first serial bit stream plus its frame-valid strobe.
//  - Reassembles each frame into a WIDTH-bit word.
//  - Presents the word to the sink through a valid/ready register slice.
//  - Closes the loop back to parallel form on the p_clk domain; flags overruns and bad frames.

---
 rtl/serial_to_parallel_receiver_if.sv | 23 ++
 rtl/serial_to_parallel_receiver.sv | 126 ++++++++++++
 tb/tb_serial_to_parallel_receiver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_receiver_if.sv
// Serial-in / parallel-out bus for serial_to_parallel_receiver.
// master drives the serial stream and sink ready; slave is the receiver.
interface serial_to_parallel_receiver_if #(
  parameter int WIDTH = 32
);
  logic             ser_in;
  logic             frame_in;
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             frame_err;

  modport master (
    output ser_in, frame_in, out_ready,
    input  par_out, out_valid, overrun, frame_err
  );

  modport slave (
    input  ser_in, frame_in, out_ready,
    output par_out, out_valid, overrun, frame_err
  );
endinterface

// File: rtl/serial_to_parallel_receiver.sv
// LSB-first serial frame receiver with a valid/ready output slot.
// Optional frame length checking is enabled by defining S2P_LEN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a frame_in rising edge
// RECV  | collecting lead-skip and payload bits
// DRAIN | word complete, ignoring extra bits until frame_in falls
module serial_to_parallel_receiver #(
  parameter int WIDTH     = 32,
  parameter int LEAD_SKIP = 1
) (
  input logic                          p_clk,
  input logic                          n_rst,
  serial_to_parallel_receiver_if.slave bus
);
  localparam int FULL  = LEAD_SKIP + WIDTH;
  localparam int CNT_W = $clog2(FULL + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FULL);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FULL + 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t           r_state;
  logic             r_frame_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_par;
  logic             r_valid;
  logic             r_overrun;
`ifdef S2P_LEN_CHECK_EN
  logic             r_frame_err;
`endif

  logic             w_start;
  logic             w_qual;
  logic             w_sample;
  logic             w_done;
  logic             w_hs;
  int               w_cnt_before;
  logic [WIDTH-1:0] w_word;

  always_comb begin
    w_start      = bus.frame_in && !r_frame_d;
    w_qual       = (r_state == IDLE) ? w_start : ((r_state == RECV) && bus.frame_in);
    w_cnt_before = (r_state == IDLE) ? 0 : int'(r_cnt);
    w_sample     = w_qual && (w_cnt_before >= LEAD_SKIP) && (w_cnt_before < FULL);
    w_done       = w_sample && (w_cnt_before == FULL - 1);
    w_word       = {bus.ser_in, r_sr[WIDTH-1:1]};
    w_hs         = r_valid && bus.out_ready;
  end

  always_ff @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_frame_d   <= 1'b1;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_par       <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef S2P_LEN_CHECK_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_frame_d   <= bus.frame_in;
      r_overrun   <= 1'b0;
`ifdef S2P_LEN_CHECK_EN
      r_frame_err <= 1'b0;
`endif
      if (w_sample) r_sr <= w_word;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt   <= CNT_ONE;
            r_state <= w_done ? DRAIN : RECV;
          end
        end
        RECV: begin
          if (bus.frame_in) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_done) r_state <= DRAIN;
          end else begin
            r_state     <= IDLE;
`ifdef S2P_LEN_CHECK_EN
            r_frame_err <= 1'b1;
`endif
          end
        end
        DRAIN: begin
          // Saturating just past FULL is enough to tell a long frame apart.
          if (bus.frame_in) begin
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_ONE;
          end else begin
            r_state     <= IDLE;
`ifdef S2P_LEN_CHECK_EN
            r_frame_err <= (r_cnt != CNT_FULL);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_done) begin
        if (!r_valid || bus.out_ready) begin
          r_par   <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.par_out   = r_par;
  assign bus.out_valid = r_valid;
  assign bus.overrun   = r_overrun;
`ifdef S2P_LEN_CHECK_EN
  assign bus.frame_err = r_frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Scoreboard bench for serial_to_parallel_receiver: a frame-level model pushes
// expected words; a negedge monitor compares every presented output.
module tb_serial_to_parallel_receiver;
  localparam int W    = 32;
  localparam int LS   = 1;
  localparam int FULL = LS + W;

  logic p_clk = 1'b0;
  logic n_rst = 1'b0;

  serial_to_parallel_receiver_if #(.WIDTH(W)) bus ();

  serial_to_parallel_receiver #(.WIDTH(W), .LEAD_SKIP(LS)) dut (
    .p_clk (p_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 p_clk = ~p_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ovr_seen = 0;
  int ready_mode = 1;

  logic [W-1:0] exp_q[$];
  bit           m_full = 1'b0;
  bit           m_prev = 1'b1;
  bit           m_in = 1'b0;
  bit           exp_ovr = 1'b0;
  bit           exp_ferr = 1'b0;
  int           m_nq = 0;
  logic [W-1:0] m_word = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of qualified bits per frame, word = bits LS..FULL-1.
  always @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      m_full   = 1'b0;
      m_prev   = 1'b1;
      m_in     = 1'b0;
      m_nq     = 0;
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
      exp_q.delete();
    end else begin
      bit done;
      bit hs;
      done     = 1'b0;
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
      if (bus.frame_in && !m_prev) begin
        m_in = 1'b1;
        m_nq = 0;
      end
      if (m_in && bus.frame_in) begin
        if (m_nq >= LS && m_nq < FULL) m_word[m_nq-LS] = bus.ser_in;
        m_nq++;
        if (m_nq == FULL) done = 1'b1;
      end else if (m_in && !bus.frame_in) begin
        m_in = 1'b0;
`ifdef S2P_LEN_CHECK_EN
        exp_ferr = (m_nq != FULL);
`endif
      end
      m_prev = bus.frame_in;
      hs = m_full && bus.out_ready;
      if (done) begin
        if (!m_full || bus.out_ready) begin
          exp_q.push_back(m_word);
          m_full = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (hs) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge p_clk) begin
    check("out_valid", bus.out_valid, m_full);
    check("overrun", bus.overrun, exp_ovr);
    check("frame_err", bus.frame_err, exp_ferr);
    if (bus.overrun) n_ovr_seen++;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL par_out: got %h expected no word at %0t", bus.par_out, $time);
      end else begin
        check("par_out", bus.par_out, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_cycle(input logic f, input logic s, input bit force_rdy);
    @(posedge p_clk);
    #1;
    bus.frame_in = f;
    bus.ser_in   = s;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (force_rdy) bus.out_ready = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int nq, input int gap,
                            input int rdy_at, input int rst_at);
    for (int i = 0; i < nq; i++) begin
      logic b;
      b = (i >= LS && i < FULL) ? word[i-LS] : 1'($urandom);
      drive_cycle(1'b1, b, i == rdy_at);
      if (i == rst_at) n_rst = 1'b0;
      if (i == rst_at + 2) n_rst = 1'b1;
    end
    for (int g = 0; g < gap; g++) drive_cycle(1'b0, 1'($urandom), 1'b0);
  endtask

  initial begin
    bus.frame_in  = 1'b0;
    bus.ser_in    = 1'b0;
    bus.out_ready = 1'b0;
    n_rst         = 1'b0;
    @(negedge p_clk);
    check("reset par_out", bus.par_out, '0);
    repeat (2) @(posedge p_clk);
    #1 n_rst = 1'b1;

    ready_mode = 1;
    send_frame(32'hA5A5_F00F, FULL, 2, -1, -1);

    ready_mode = 0;
    send_frame(32'h0000_0001, FULL, 1, -1, -1);
    send_frame(32'h8000_0000, FULL, 3, -1, -1);
    @(negedge p_clk);
    check("held word", bus.par_out, 32'h0000_0001);
    check("overrun count", n_ovr_seen, 1);
    ready_mode = 1;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);

    ready_mode = 2;
    send_frame($urandom, 20, 2, -1, -1);
    send_frame(32'hDEAD_BEEF, FULL + 1, 2, -1, -1);

    send_frame($urandom, FULL, 2, -1, 15);
    @(negedge p_clk);
    check("post-reset par_out", bus.par_out, '0);
    send_frame(32'h1234_5678, FULL, 2, -1, -1);
    ready_mode = 1;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);

    ready_mode = 0;
    send_frame(32'h1111_0000, FULL, 1, -1, -1);
    send_frame(32'hCAFE_0001, FULL, 1, FULL - 1, -1);
    @(negedge p_clk);
    check("same-cycle reload", bus.par_out, 32'hCAFE_0001);
    ready_mode = 1;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);

    ready_mode = 2;
    repeat (150) begin
      int r;
      int nq;
      r  = $urandom_range(0, 3);
      nq = (r == 0) ? $urandom_range(1, FULL - 1) :
           (r == 1) ? FULL + $urandom_range(1, 3) : FULL;
      send_frame($urandom, nq, $urandom_range(1, 3), -1, -1);
    end

    ready_mode = 1;
    repeat (5) drive_cycle(1'b0, 1'b0, 1'b0);
    @(negedge p_clk);
    check("queue drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
